res_reader: RTL and testbench

// - Drains the two result buffers (lane 1 = sum1 results, lane 2 = sum2 results) after a convolve/pool pass.
// - Issues synchronous reads on a shared read address and serialises the results onto one valid/ready stream.
// - Sits between the result buffers and the downstream consumer (next layer loader or host readout).
// - Order per address A: lane-1 word, then lane-2 word. Addresses run 0 .. num_words-1.

---
 rtl/res_reader.sv | 161 ++++++++++++++++
 tb/tb_res_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_reader.sv
// res_reader: drains the two result buffers after a convolve/pool pass.
//
// For each address 0 .. num_words-1 one synchronous read is issued to both
// buffers on the shared rd_addr. The two returned words are then sent on a
// single valid/ready stream: the lane-1 word first, then the lane-2 word.
// out_last marks the lane-2 word of the final address. done pulses for one
// cycle when the drain completes.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-low
//   start      begin a drain (sampled only when idle)
//   num_words  words per lane to drain, latched when start is accepted
//   rd_en      read strobe to both result buffers
//   rd_addr    read address to both result buffers
//   rd_data1   lane-1 buffer data, valid one cycle after rd_en
//   rd_data2   lane-2 buffer data, same timing as rd_data1
//   out_data   stream data
//   out_valid  stream valid
//   out_ready  stream ready
//   out_last   final word of the drain
//   busy       high whenever not idle
//   done       one-cycle completion pulse
module res_reader #(
    parameter int unsigned BIT_DEPTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BIT_DEPTH-1:0]  rd_data1,
    input  logic [BIT_DEPTH-1:0]  rd_data2,
    output logic [BIT_DEPTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend1,
        StSend2,
        StFinish
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] num_words_q, num_words_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [BIT_DEPTH-1:0]  hold2_q, hold2_d;
    logic [BIT_DEPTH-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] last_addr;

    // Only meaningful once a non-zero count is latched, so no underflow case.
    assign last_addr = num_words_q - ADDR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        num_words_d = num_words_q;
        rd_addr_d   = rd_addr_q;
        hold2_d     = hold2_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_words_d = num_words;
                    rd_addr_d   = '0;
                    state_d     = (num_words == '0) ? StFinish : StFetch;
                end
            end
            StFetch: begin
                state_d = StCapture;
            end
            StCapture: begin
                // Lane-1 word goes straight to the output register; lane-2 waits.
                out_data_d = rd_data1;
                hold2_d    = rd_data2;
                out_last_d = 1'b0;
                state_d    = StSend1;
            end
            StSend1: begin
                if (out_ready) begin
                    out_data_d = hold2_q;
                    out_last_d = (rd_addr_q == last_addr);
                    state_d    = StSend2;
                end
            end
            StSend2: begin
                if (out_ready) begin
                    out_last_d = 1'b0;
                    if (out_last_q) begin
                        state_d = StFinish;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                        state_d   = StFetch;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered versions of the next-state decode.
        rd_en_d     = (state_d == StFetch);
        out_valid_d = (state_d == StSend1) || (state_d == StSend2);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            num_words_q <= '0;
            rd_addr_q   <= '0;
            hold2_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_words_q <= num_words_d;
            rd_addr_q   <= rd_addr_d;
            hold2_q     <= hold2_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rd_en_q     <= rd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_res_reader.sv
// Directed testbench for res_reader: reset, basic drain, backpressure,
// zero-length drain, ignored start and reset in the middle of a drain.
module tb_res_reader;

    localparam int BD = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_words = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [BD-1:0] rd_data1;
    logic [BD-1:0] rd_data2;
    logic [BD-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    res_reader #(
        .BIT_DEPTH (BD),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_words(num_words),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // Result buffers with a registered read port.
    logic [BD-1:0] mem1 [0:(1<<AW)-1];
    logic [BD-1:0] mem2 [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem1[rd_addr];
            rd_data2 <= mem2[rd_addr];
        end
    end

    // Expected stream for the 3-address drain.
    logic [BD-1:0] exp_seq [6] = '{8'd10, 8'd20, 8'd11, 8'd21, 8'd12, 8'd22};

    int total = 0;
    int bad = 0;

    // Stream monitor: records transfers and event counts; tests use deltas.
    int            cyc = 0;
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            viol = 0;
    int            last_xfer_cyc = -1;
    int            last_done_cyc = -1;
    logic [BD-1:0] got_data [$];
    logic          got_last [$];
    logic          prev_stall = 1'b0;
    logic [BD-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            last_xfer_cyc <= cyc;
        end
        // A stalled word must stay valid with unchanged data/last.
        if (rst && prev_stall &&
            (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
            viol <= viol + 1;
        prev_stall <= rst && out_valid && !out_ready;
        prev_data  <= out_data;
        prev_last  <= out_last;
    end

    int base_rd, base_done, base_x, base_viol;

    task automatic snap();
        base_rd   = rd_cnt;
        base_done = done_cnt;
        base_x    = got_data.size();
        base_viol = viol;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] n);
        num_words = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start     = 1'b1;
        num_words = 10'd3;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        total++; if (rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (rd_cnt !== 0) begin bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_cnt); end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_stream(input string name);
        total++;
        if (got_data.size() - base_x !== 6) begin
            bad++;
            $display("FAIL %s_count got=%0d exp=6", name, got_data.size() - base_x);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (got_data[base_x+i] !== exp_seq[i]) begin
                    bad++;
                    $display("FAIL %s_data[%0d] got=%0d exp=%0d", name, i, got_data[base_x+i],
                             exp_seq[i]);
                end
                total++;
                if (got_last[base_x+i] !== (i == 5)) begin
                    bad++;
                    $display("FAIL %s_last[%0d] got=%b exp=%b", name, i, got_last[base_x+i], i == 5);
                end
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        snap();
        out_ready = 1'b1;
        pulse_start(10'd3);
        // First cycle after the accepting edge: read strobe for address 0.
        total++; if (rd_en !== 1'b1 || rd_addr !== 10'd0) begin bad++; $display("FAIL basic_fetch got rd_en=%b addr=%0d exp rd_en=1 addr=0", rd_en, rd_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        @(negedge clk);
        total++; if (rd_en !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_capture got rd_en=%b valid=%b exp 0 0", rd_en, out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'd10) begin bad++; $display("FAIL basic_first got valid=%b data=%0d exp 1 10", out_valid, out_data); end
        wait_idle(60, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%b exp=1", ok); end
        check_stream("basic");
        total++; if (done_cnt - base_done !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - base_done); end
        total++; if (rd_cnt - base_rd !== 3) begin bad++; $display("FAIL basic_rd_count got=%0d exp=3", rd_cnt - base_rd); end
        total++; if (last_done_cyc - last_xfer_cyc !== 1) begin bad++; $display("FAIL basic_done_timing got=%0d exp=1", last_done_cyc - last_xfer_cyc); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int stall;
        snap();
        stall     = 0;
        ok        = 1'b0;
        out_ready = 1'b0;
        pulse_start(10'd3);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (out_valid && out_data == 8'd11 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = k[0];
            end
        end
        out_ready = 1'b1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", ok); end
        total++; if (stall !== 5) begin bad++; $display("FAIL bp_stall_len got=%0d exp=5", stall); end
        check_stream("bp");
        total++; if (viol - base_viol !== 0) begin bad++; $display("FAIL bp_stable got=%0d violations exp=0", viol - base_viol); end
        total++; if (rd_cnt - base_rd !== 3) begin bad++; $display("FAIL bp_rd_count got=%0d exp=3", rd_cnt - base_rd); end
        total++; if (done_cnt - base_done !== 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt - base_done); end
    endtask

    task automatic test_zero_length();
        snap();
        pulse_start(10'd0);
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_finish got done=%b busy=%b exp 1 1", done, busy); end
        total++; if (rd_en !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL zero_quiet got rd_en=%b valid=%b exp 0 0", rd_en, out_valid); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_idle got done=%b busy=%b exp 0 0", done, busy); end
        total++; if (rd_cnt - base_rd !== 0) begin bad++; $display("FAIL zero_rd_count got=%0d exp=0", rd_cnt - base_rd); end
        total++; if (got_data.size() - base_x !== 0) begin bad++; $display("FAIL zero_xfers got=%0d exp=0", got_data.size() - base_x); end
        total++; if (done_cnt - base_done !== 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - base_done); end
    endtask

    task automatic test_ignored_start();
        bit ok;
        snap();
        out_ready = 1'b1;
        pulse_start(10'd3);
        @(negedge clk);
        num_words = 10'd1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        repeat (4) @(negedge clk);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_idle(60, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ign_timeout got=%b exp=1", ok); end
        check_stream("ign");
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart got busy=%b exp=0", busy); end
        total++; if (done_cnt - base_done !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt - base_done); end
        total++; if (rd_cnt - base_rd !== 3) begin bad++; $display("FAIL ign_rd_count got=%0d exp=3", rd_cnt - base_rd); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit found;
        snap();
        found     = 1'b0;
        out_ready = 1'b1;
        pulse_start(10'd3);
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_data == 8'd11) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL mrst_reach_send1 got=%b exp=1", found); end
        out_ready = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        total++; if (rd_en !== 1'b0 || rd_addr !== '0) begin bad++; $display("FAIL mrst_rd got rd_en=%b addr=%0d exp 0 0", rd_en, rd_addr); end
        total++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin bad++; $display("FAIL mrst_stream got valid=%b data=%0d last=%b exp 0 0 0", out_valid, out_data, out_last); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mrst_status got busy=%b done=%b exp 0 0", busy, done); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (done_cnt - base_done !== 0) begin bad++; $display("FAIL mrst_no_done got=%0d exp=0", done_cnt - base_done); end
        total++; if (rd_cnt - base_rd !== 2) begin bad++; $display("FAIL mrst_rd_count got=%0d exp=2", rd_cnt - base_rd); end
        total++; if (got_data.size() - base_x !== 2) begin bad++; $display("FAIL mrst_xfers got=%0d exp=2", got_data.size() - base_x); end
        snap();
        out_ready = 1'b1;
        pulse_start(10'd3);
        total++; if (rd_en !== 1'b1 || rd_addr !== 10'd0) begin bad++; $display("FAIL mrst_restart got rd_en=%b addr=%0d exp 1 0", rd_en, rd_addr); end
        wait_idle(60, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mrst_timeout got=%b exp=1", ok); end
        check_stream("mrst");
        total++; if (done_cnt - base_done !== 1) begin bad++; $display("FAIL mrst_done_count got=%0d exp=1", done_cnt - base_done); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem1[i] = 8'hEE;
            mem2[i] = 8'hDD;
        end
        for (int i = 0; i < 3; i++) begin
            mem1[i] = 8'(10 + i);
            mem2[i] = 8'(20 + i);
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_ignored_start();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
